// File: rtl/zelda_pkg.sv
// Shared types and screen constants for the Zelda sprite pipeline.
package zelda_pkg;

    typedef enum logic [2:0] {IDLE, F1, F2, F3, RECOVER} sword_state_t;
    typedef enum logic [1:0] {DIR_DOWN, DIR_UP, DIR_LEFT, DIR_RIGHT} dir_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

endpackage

// File: rtl/sprite_addr_gen.sv
// Pipelined box test, optional horizontal mirror and ROM address generator.
// The address is registered once; valid is delayed STAGES cycles to line up with the ROM output.
module sprite_addr_gen #(
    parameter int SPRITE_W = 32,
    parameter int AW       = 2 * $clog2(SPRITE_W),
    parameter int STAGES   = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [9:0]    draw_x,
    input  logic [9:0]    draw_y,
    input  logic [9:0]    org_x,
    input  logic [9:0]    org_y,
    input  logic          mirror,
    input  logic          blank,
    input  logic          en,
    output logic [AW-1:0] addr,
    output logic          valid
);

    localparam int LW = $clog2(SPRITE_W);
    localparam logic [9:0] SW = 10'(SPRITE_W);

    logic [10:0]       dx, dy;
    logic              in_box;
    logic [LW-1:0]     col, row;
    logic [AW-1:0]     addr_d, addr_q;
    logic [STAGES:1]   vld_pipe_d, vld_pipe_q;

    always_comb begin
        dx     = {1'b0, draw_x} - {1'b0, org_x};
        dy     = {1'b0, draw_y} - {1'b0, org_y};
        // Bit 10 is the sign: a negative offset is outside the box.
        in_box = !dx[10] && !dy[10] && (dx[9:0] < SW) && (dy[9:0] < SW);
        // SPRITE_W-1-dx equals ~dx in the low bits for a power-of-two width.
        col    = dx[LW-1:0] ^ {LW{mirror}};
        row    = dy[LW-1:0];
        addr_d = in_box ? {row, col} : '0;
        vld_pipe_d = {vld_pipe_q[STAGES-1:1], in_box & blank & en};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            vld_pipe_q <= '0;
        end else begin
            addr_q     <= addr_d;
            vld_pipe_q <= vld_pipe_d;
        end
    end

    assign addr  = addr_q;
    assign valid = vld_pipe_q[STAGES];

endmodule

// File: rtl/sword_anim_ctrl.sv
// Sword-attack animation sequencer: vsync tick detect, frame FSM and sprite ROM addressing.
module sword_anim_ctrl
    import zelda_pkg::*;
#(
    parameter int SPRITE_W        = 32,
    parameter int TICKS_PER_FRAME = 4,
    parameter int COOLDOWN_TICKS  = 8
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    input  logic       vs,
    input  logic       attack_req,
    input  logic [1:0] dir,
    input  logic [9:0] link_x,
    input  logic [9:0] link_y,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       blank,
    output logic [1:0] frame_sel,
    output logic [1:0] dir_sel,
    output logic [9:0] rom_address,
    output logic       sprite_valid,
    output logic       busy,
    output logic       attack_done
);

    localparam int CNT_MAX = (TICKS_PER_FRAME > COOLDOWN_TICKS) ? TICKS_PER_FRAME : COOLDOWN_TICKS;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] FRAME_LAST = CW'(TICKS_PER_FRAME - 1);
    localparam logic [CW-1:0] COOL_LAST  = CW'(COOLDOWN_TICKS - 1);

    sword_state_t  state_d, state_q;
    logic [CW-1:0] cnt_d, cnt_q;
    logic [1:0]    dir_d, dir_q;
    logic          done_d, done_q;
    logic          vs_s1_q, vs_s2_q, vs_prev_q;
    logic          tick;

    // vsync is asynchronous to the pixel clock; history resets high so no false tick.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            vs_s1_q   <= 1'b1;
            vs_s2_q   <= 1'b1;
            vs_prev_q <= 1'b1;
        end else begin
            vs_s1_q   <= vs;
            vs_s2_q   <= vs_s1_q;
            vs_prev_q <= vs_s2_q;
        end
    end

    assign tick = vs_prev_q & ~vs_s2_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: if (tick && attack_req) begin
                dir_d   = dir;
                cnt_d   = '0;
                state_d = F1;
            end
            F1, F2, F3: if (tick) begin
                if (cnt_q == FRAME_LAST) begin
                    cnt_d   = '0;
                    state_d = (state_q == F1) ? F2 : (state_q == F2) ? F3 : RECOVER;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RECOVER: if (tick) begin
                if (cnt_q == COOL_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dir_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        unique case (state_q)
            F1:      frame_sel = 2'd1;
            F2:      frame_sel = 2'd2;
            F3:      frame_sel = 2'd3;
            default: frame_sel = 2'd0;
        endcase
    end

    assign busy        = (state_q != IDLE);
    assign dir_sel     = dir_q;
    assign attack_done = done_q;

    sprite_addr_gen #(.SPRITE_W(SPRITE_W)) u_addr (
        .clk    (vga_clk),
        .rst_n  (reset_n),
        .draw_x (DrawX),
        .draw_y (DrawY),
        .org_x  (link_x),
        .org_y  (link_y),
        .mirror (dir_q == DIR_LEFT),
        .blank  (blank),
        .en     (frame_sel != 2'd0),
        .addr   (rom_address),
        .valid  (sprite_valid)
    );

endmodule
